// File: rtl/stream_unit_initiator.sv
// Fills the stream unit's memory with seed+i, then streams address/operand pairs and
// checks every response against (seed+i) ^ (key+i). Payloads derive from registered state only.
module stream_unit_initiator #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_count,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [DATA_WIDTH-1:0] cfg_key,
  input  logic                  rsp_stall,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_index,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  cmd_a_valid,
  input  logic                  cmd_a_ready,
  output logic [ADDR_WIDTH-1:0] cmd_a_payload,
  output logic                  cmd_b_valid,
  input  logic                  cmd_b_ready,
  output logic [DATA_WIDTH-1:0] cmd_b_payload,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [DATA_WIDTH-1:0] rsp_payload
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [CNT_WIDTH-1:0]  w_idx_q, w_idx_d;
  logic [CNT_WIDTH-1:0]  a_idx_q, a_idx_d;
  logic [CNT_WIDTH-1:0]  b_idx_q, b_idx_d;
  logic [CNT_WIDTH-1:0]  r_idx_q, r_idx_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic                  first_err_valid_q, first_err_valid_d;
  logic [ADDR_WIDTH-1:0] first_err_index_q, first_err_index_d;

  logic                  cmd_a_fire, cmd_b_fire, rsp_fire;
  logic [DATA_WIDTH-1:0] rsp_expected;

  function automatic logic [DATA_WIDTH-1:0] widen(input logic [CNT_WIDTH-1:0] v);
    return DATA_WIDTH'(v);
  endfunction

  assign busy              = (state_q == FILL) || (state_q == RUN);
  assign done              = (state_q == DONE);
  assign err_count         = err_count_q;
  assign first_err_valid   = first_err_valid_q;
  assign first_err_index   = first_err_index_q;
  assign mem_write_valid   = (state_q == FILL);
  assign mem_write_address = w_idx_q[ADDR_WIDTH-1:0];
  assign mem_write_data    = seed_q + widen(w_idx_q);
  assign cmd_a_valid       = (state_q == RUN) && (a_idx_q < n_q);
  assign cmd_a_payload     = a_idx_q[ADDR_WIDTH-1:0];
  assign cmd_b_valid       = (state_q == RUN) && (b_idx_q < n_q);
  assign cmd_b_payload     = key_q + widen(b_idx_q);
  // Ready is held low outside RUN so stray or surplus responses are never consumed.
  assign rsp_ready         = (state_q == RUN) && !rsp_stall;

  assign cmd_a_fire   = cmd_a_valid && cmd_a_ready;
  assign cmd_b_fire   = cmd_b_valid && cmd_b_ready;
  assign rsp_fire     = rsp_valid && rsp_ready;
  assign rsp_expected = (seed_q + widen(r_idx_q)) ^ (key_q + widen(r_idx_q));

  always_comb begin
    state_d           = state_q;
    n_d               = n_q;
    w_idx_d           = w_idx_q;
    a_idx_d           = a_idx_q;
    b_idx_d           = b_idx_q;
    r_idx_d           = r_idx_q;
    seed_d            = seed_q;
    key_d             = key_q;
    err_count_d       = err_count_q;
    first_err_valid_d = first_err_valid_q;
    first_err_index_d = first_err_index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d               = cfg_count;
          seed_d            = cfg_seed;
          key_d             = cfg_key;
          err_count_d       = '0;
          first_err_valid_d = 1'b0;
          first_err_index_d = '0;
          w_idx_d           = '0;
          a_idx_d           = '0;
          b_idx_d           = '0;
          r_idx_d           = '0;
          state_d           = (cfg_count == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        w_idx_d = w_idx_q + CNT_ONE;
        if (w_idx_q == n_q - CNT_ONE) state_d = RUN;
      end
      RUN: begin
        if (cmd_a_fire) a_idx_d = a_idx_q + CNT_ONE;
        if (cmd_b_fire) b_idx_d = b_idx_q + CNT_ONE;
        if (rsp_fire) begin
          if (rsp_payload != rsp_expected) begin
            err_count_d = err_count_q + CNT_ONE;
            if (!first_err_valid_q) begin
              first_err_valid_d = 1'b1;
              first_err_index_d = r_idx_q[ADDR_WIDTH-1:0];
            end
          end
          r_idx_d = r_idx_q + CNT_ONE;
          if (r_idx_q == n_q - CNT_ONE) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      n_q               <= '0;
      w_idx_q           <= '0;
      a_idx_q           <= '0;
      b_idx_q           <= '0;
      r_idx_q           <= '0;
      seed_q            <= '0;
      key_q             <= '0;
      err_count_q       <= '0;
      first_err_valid_q <= 1'b0;
      first_err_index_q <= '0;
    end else begin
      state_q           <= state_d;
      n_q               <= n_d;
      w_idx_q           <= w_idx_d;
      a_idx_q           <= a_idx_d;
      b_idx_q           <= b_idx_d;
      r_idx_q           <= r_idx_d;
      seed_q            <= seed_d;
      key_q             <= key_d;
      err_count_q       <= err_count_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_index_q <= first_err_index_d;
    end
  end
endmodule

// File: tb/tb_stream_unit_initiator.sv
// Bench for stream_unit_initiator: a behavioural stream-unit responder (memory + XOR) with
// injectable corruption and backpressure; expectations come from the job's seed/key/count rules.
`timescale 1ns/1ps
module tb_stream_unit_initiator;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int CW = AW + 1;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, rsp_stall = 1'b0;
  logic [CW-1:0] cfg_count = '0;
  logic [DW-1:0] cfg_seed = '0, cfg_key = '0;
  logic          busy, done, first_err_valid, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready;
  logic [CW-1:0] err_count;
  logic [AW-1:0] first_err_index, mem_write_address, cmd_a_payload;
  logic [DW-1:0] mem_write_data, cmd_b_payload;
  logic          cmd_a_ready = 1'b0, cmd_b_ready = 1'b0, rsp_valid = 1'b0;
  logic [DW-1:0] rsp_payload = '0;

  stream_unit_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_count(cfg_count), .cfg_seed(cfg_seed),
    .cfg_key(cfg_key), .rsp_stall(rsp_stall), .busy(busy), .done(done), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_index(first_err_index),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .cmd_a_valid(cmd_a_valid), .cmd_a_ready(cmd_a_ready),
    .cmd_a_payload(cmd_a_payload), .cmd_b_valid(cmd_b_valid), .cmd_b_ready(cmd_b_ready),
    .cmd_b_payload(cmd_b_payload), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload(rsp_payload)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Responder knobs
  int stall_mode = 0, rdy_rand = 0, b_block = 0, corrupt_idx = -1;

  // Stream-unit model state
  logic [DW-1:0] mem [256];
  logic [AW-1:0] aq [$];
  logic [DW-1:0] bq [$];
  logic [DW-1:0] rq [$];
  int            rsp_made = 0;

  // Observations
  logic [AW-1:0] w_addr_obs [$];
  logic [DW-1:0] w_data_obs [$];
  logic [AW-1:0] a_obs [$];
  logic [DW-1:0] b_obs [$];
  logic [DW-1:0] rsp_obs [$];
  int r_acc = 0, done_cnt = 0, busy_cnt = 0, stray = 0, hold_viol = 0, b_held = 0;
  int cyc = 0, done_cyc = -1, last_r_cyc = -2, first_w_cyc = -1, last_w_cyc = -1, last_lat = 0;

  bit            pend_w = 0, pend_a = 0, pend_b = 0, pend_r = 0, a_wait = 0, b_wait = 0;
  logic [AW-1:0] pw_addr, pa, a_wait_pay;
  logic [DW-1:0] pw_data, pb, pr_dat, b_wait_pay;

  // Inputs change on the falling edge; fires seen just after are the ones the next rising edge takes.
  always @(negedge clk) begin
    logic [DW-1:0] d;
    cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (!busy && (mem_write_valid || cmd_a_valid || cmd_b_valid)) stray++;
    if (rsp_ready && (!busy || mem_write_valid)) stray++;
    if (reset) begin
      pend_w = 0; pend_a = 0; pend_b = 0; pend_r = 0; a_wait = 0; b_wait = 0;
      aq.delete(); bq.delete(); rq.delete();
    end else begin
      if (pend_w) begin
        mem[pw_addr] = pw_data;
        w_addr_obs.push_back(pw_addr); w_data_obs.push_back(pw_data);
        if (first_w_cyc < 0) first_w_cyc = cyc;
        last_w_cyc = cyc;
      end
      if (pend_a) begin aq.push_back(pa); a_obs.push_back(pa); end
      if (pend_b) begin bq.push_back(pb); b_obs.push_back(pb); end
      if (pend_r) begin void'(rq.pop_front()); rsp_obs.push_back(pr_dat); r_acc++; last_r_cyc = cyc; end
      while (aq.size() > 0 && bq.size() > 0) begin
        d = mem[aq.pop_front()] ^ bq.pop_front();
        if (rsp_made == corrupt_idx) d[0] = ~d[0];
        rq.push_back(d);
        rsp_made++;
      end
    end
    cmd_a_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (b_block > 0) begin
      cmd_b_ready = 1'b0;
      if (cmd_b_valid) b_block--;
    end else cmd_b_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    case (stall_mode)
      1:       if (cyc % 3 == 0) rsp_stall = ~rsp_stall;
      2:       rsp_stall = ($urandom_range(0, 2) == 0);
      default: rsp_stall = 1'b0;
    endcase
    rsp_valid   = (rq.size() > 0);
    rsp_payload = (rq.size() > 0) ? rq[0] : '0;
    #1;
    if (!reset) begin
      if (a_wait && (!cmd_a_valid || cmd_a_payload !== a_wait_pay)) hold_viol++;
      if (b_wait && (!cmd_b_valid || cmd_b_payload !== b_wait_pay)) hold_viol++;
      if (cmd_b_valid && !cmd_b_ready) b_held++;
      pend_w = mem_write_valid;  pw_addr = mem_write_address; pw_data = mem_write_data;
      pend_a = cmd_a_valid && cmd_a_ready; pa = cmd_a_payload;
      pend_b = cmd_b_valid && cmd_b_ready; pb = cmd_b_payload;
      pend_r = rsp_valid && rsp_ready;     pr_dat = rsp_payload;
      a_wait = cmd_a_valid && !cmd_a_ready; a_wait_pay = cmd_a_payload;
      b_wait = cmd_b_valid && !cmd_b_ready; b_wait_pay = cmd_b_payload;
    end
  end

  task automatic clear_obs;
    w_addr_obs.delete(); w_data_obs.delete(); a_obs.delete(); b_obs.delete(); rsp_obs.delete();
    r_acc = 0; done_cnt = 0; busy_cnt = 0; stray = 0; hold_viol = 0; b_held = 0; rsp_made = 0;
    done_cyc = -1; last_r_cyc = -2; first_w_cyc = -1; last_w_cyc = -1;
  endtask

  task automatic pulse_start(input int n, input logic [DW-1:0] s, input logic [DW-1:0] k);
    @(posedge clk); #2;
    start = 1'b1; cfg_count = CW'(n); cfg_seed = s; cfg_key = k;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 000000",
                         {busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready});
    end
    checks++;
    if ({err_count, first_err_valid, first_err_index} !== '0) begin
      errors++; $display("FAIL reset_err: got cnt=%0d fev=%0b fei=%0d required 0 0 0",
                         err_count, first_err_valid, first_err_index);
    end
    checks++;
    if ({mem_write_address, mem_write_data, cmd_a_payload, cmd_b_payload} !== '0) begin
      errors++; $display("FAIL reset_payload: got %0h %0h %0h %0h required all 0",
                         mem_write_address, mem_write_data, cmd_a_payload, cmd_b_payload);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready} !== 6'b0) begin
      errors++; $display("FAIL idle_after_reset: got %b required 000000",
                         {busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready});
    end
  endtask

  task automatic test_job(input string name, input int n, input logic [DW-1:0] s,
                          input logic [DW-1:0] k, input int corrupt, input int stall,
                          input int rdy, input int bblk);
    int lat, bad, exp_err;
    clear_obs();
    corrupt_idx = corrupt; stall_mode = stall; rdy_rand = rdy; b_block = bblk;
    pulse_start(n, s, k);
    if (n > 0) begin
      checks++;
      if (!(busy && mem_write_valid && mem_write_address == 0 && mem_write_data == s)) begin
        errors++; $display("FAIL %s first_write: busy=%0b vld=%0b addr=%0h data=%0h required 1 1 0 %0h",
                           name, busy, mem_write_valid, mem_write_address, mem_write_data, s);
      end
    end
    lat = 0;
    while (!done && lat < 20 * n + 100) begin @(posedge clk); #2; lat++; end
    last_lat = lat;
    checks++;
    if (!done) begin errors++; $display("FAIL %s done_timeout: done=%0b after %0d cycles required 1", name, done, lat); end
    repeat (3) @(posedge clk);
    #2;
    stall_mode = 0; rdy_rand = 0; b_block = 0;
    exp_err = (corrupt >= 0 && corrupt < n) ? 1 : 0;

    bad = 0;
    foreach (w_data_obs[i]) if (w_addr_obs[i] !== AW'(i) || w_data_obs[i] !== s + DW'(i)) bad++;
    checks++;
    if (w_data_obs.size() != n || bad != 0) begin
      errors++; $display("FAIL %s writes: got %0d writes %0d wrong required %0d writes 0 wrong", name, w_data_obs.size(), bad, n);
    end
    bad = 0;
    foreach (a_obs[i]) if (a_obs[i] !== AW'(i)) bad++;
    checks++;
    if (a_obs.size() != n || bad != 0) begin
      errors++; $display("FAIL %s cmd_a: got %0d fires %0d wrong required %0d fires 0 wrong", name, a_obs.size(), bad, n);
    end
    bad = 0;
    foreach (b_obs[i]) if (b_obs[i] !== k + DW'(i)) bad++;
    checks++;
    if (b_obs.size() != n || bad != 0) begin
      errors++; $display("FAIL %s cmd_b: got %0d fires %0d wrong required %0d fires 0 wrong", name, b_obs.size(), bad, n);
    end
    checks++;
    if (r_acc != n) begin errors++; $display("FAIL %s rsp_accepted: got %0d required %0d", name, r_acc, n); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt); end
    if (n > 0) begin
      checks++;
      if (done_cyc != last_r_cyc) begin
        errors++; $display("FAIL %s done_latency: done at cycle %0d required %0d", name, done_cyc, last_r_cyc);
      end
    end
    checks++;
    if (err_count !== CW'(exp_err) || first_err_valid !== (exp_err == 1)) begin
      errors++; $display("FAIL %s err: got cnt=%0d fev=%0b required %0d %0b", name, err_count, first_err_valid, exp_err, exp_err == 1);
    end
    checks++;
    if (first_err_index !== ((exp_err == 1) ? AW'(corrupt) : AW'(0))) begin
      errors++; $display("FAIL %s first_err_index: got %0d required %0d", name, first_err_index, (exp_err == 1) ? corrupt : 0);
    end
    checks++;
    if (stray != 0 || hold_viol != 0) begin
      errors++; $display("FAIL %s protocol: stray=%0d hold_viol=%0d required 0 0", name, stray, hold_viol);
    end
  endtask

  task automatic test_basic;
    logic [DW-1:0] exp_rsp [4];
    logic [DW-1:0] got;
    exp_rsp = '{32'h1A5, 32'h1A7, 32'h1A5, 32'h1AB};
    test_job("basic", 4, 32'h100, 32'hA5, -1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      got = (i < rsp_obs.size()) ? rsp_obs[i] : 'x;
      checks++;
      if (got !== exp_rsp[i]) begin errors++; $display("FAIL basic_rsp[%0d]: got %0h required %0h", i, got, exp_rsp[i]); end
    end
  endtask

  task automatic test_backpressure;
    test_job("backpressure", 4, 32'h100, 32'hA5, -1, 1, 0, 10);
    checks++;
    if (b_held < 10) begin errors++; $display("FAIL bp_b_stall: got %0d held cycles required >= 10", b_held); end
  endtask

  task automatic test_corrupt;
    test_job("corrupt", 4, 32'h100, 32'hA5, 2, 0, 0, 0);
  endtask

  task automatic test_wrap;
    test_job("wrap", 256, 32'hFFFF_FFFE, 32'h0, -1, 0, 0, 0);
    checks++;
    if (w_data_obs.size() < 3 || w_data_obs[2] !== 32'h0) begin
      errors++; $display("FAIL wrap_data2: got %0d writes required data 0 at address 2", w_data_obs.size());
    end
    checks++;
    if (last_w_cyc - first_w_cyc != 255) begin
      errors++; $display("FAIL wrap_b2b: got span %0d required 255", last_w_cyc - first_w_cyc);
    end
  endtask

  task automatic test_zero;
    test_job("zero", 0, 32'h1234, 32'h5678, -1, 0, 0, 0);
    checks++;
    if (busy_cnt != 0 || last_lat > 1) begin
      errors++; $display("FAIL zero_job: busy cycles=%0d done latency=%0d required 0 and <=1", busy_cnt, last_lat);
    end
  endtask

  task automatic test_reset_mid;
    int w;
    clear_obs();
    corrupt_idx = -1; stall_mode = 0; rdy_rand = 0; b_block = 0;
    pulse_start(4, 32'h100, 32'hA5);
    w = 0;
    do begin @(negedge clk); #2; w++; end while (r_acc < 2 && w < 100);
    checks++;
    if (r_acc != 2 || !busy) begin errors++; $display("FAIL rmid_setup: got r_acc=%0d busy=%0b required 2 1", r_acc, busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready} !== 6'b0) begin
      errors++; $display("FAIL rmid_drop: got %b required 000000",
                         {busy, done, mem_write_valid, cmd_a_valid, cmd_b_valid, rsp_ready});
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b0 || err_count !== '0 || first_err_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_idle: got busy=%0b cnt=%0d fev=%0b required 0 0 0", busy, err_count, first_err_valid);
    end
    clear_obs();
    pulse_start(4, 32'h200, 32'h3C);
    @(posedge clk); #2;
    start = 1'b1; cfg_count = '0; cfg_seed = 32'hDEAD; cfg_key = 32'hBEEF;
    @(posedge clk); #2;
    start = 1'b0;
    w = 0;
    while (!done && w < 200) begin @(posedge clk); #2; w++; end
    repeat (3) @(posedge clk);
    #2;
    w = 0;
    foreach (w_data_obs[i]) if (w_data_obs[i] !== 32'h200 + DW'(i)) w++;
    checks++;
    if (w_data_obs.size() != 4 || w != 0 || r_acc != 4 || done_cnt != 1 || err_count !== '0) begin
      errors++; $display("FAIL rmid_ignore_start: writes=%0d wrong=%0d rsp=%0d done=%0d err=%0d required 4 0 4 1 0",
                         w_data_obs.size(), w, r_acc, done_cnt, err_count);
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 4; j++) begin
      int n;
      n = $urandom_range(1, 24);
      test_job("random", n, $urandom, $urandom, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1, 2, 1, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_corrupt();
    test_wrap();
    test_zero();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
